// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling, 5-8 data bits, optional parity,
// 1-2 stop bits, sticky error flags, and a first-word-fall-through receive FIFO.
module uart_rx_param #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    input  logic                          err_clr,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun
);
    localparam int unsigned DIV = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LW  = PW + 1;

    localparam logic [CW-1:0] CNT_MID  = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(DIV - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STP = 4'(STOP_BITS - 1);
    localparam logic          PAR_ODD  = (PARITY == 2);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic [1:0]           sync;
    logic                 rx_s;
    state_t               state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_acc;
    logic                 par_bad;
    logic                 stop_bad;

    logic                 sample_end;
    logic                 last_stop;
    logic                 stop_low;
    logic                 push_req;
    logic                 perr_set;
    logic                 pop;
    logic                 full;
    logic                 push_ok;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wptr;
    logic [PW-1:0]        rptr;

    assign rx_s = sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[0], rx};
        end
    end

    // Frame outcome is decided on the edge of the final stop-bit sample.
    always_comb begin
        sample_end = (cnt == CNT_END);
        last_stop  = (state == S_STOP) && sample_end && (bit_idx == LAST_STP);
        stop_low   = last_stop && (stop_bad || !rx_s);
        push_req   = last_stop && !stop_low && !par_bad;
        perr_set   = last_stop && !stop_low && par_bad;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            par_acc  <= 1'b0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state    <= S_DATA;
                            bit_idx  <= '0;
                            par_acc  <= 1'b0;
                            par_bad  <= 1'b0;
                            stop_bad <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (sample_end) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ rx_s;
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PAR: begin
                    if (sample_end) begin
                        cnt     <= '0;
                        par_bad <= ((par_acc ^ rx_s) != PAR_ODD);
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (sample_end) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            stop_bad <= 1'b1;
                        end
                        if (bit_idx == LAST_STP) begin
                            bit_idx <= '0;
                            state   <= stop_low ? S_WAIT_HIGH : S_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    always_comb begin
        pop     = rd_en && rd_valid;
        full    = (level == FULL_LVL);
        push_ok = push_req && (!full || pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= shift;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push_ok && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push_ok) begin
                level <= level - 1'b1;
            end
        end
    end

    assign rd_valid = (level != '0);
    assign rd_data  = mem[rptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (perr_set) begin
                parity_err <= 1'b1;
            end else if (err_clr) begin
                parity_err <= 1'b0;
            end
            if (stop_low) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (push_req && !push_ok) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
